// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package rf_arb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_entry_t;
endpackage

// File: rtl/rf_arb_buf.sv
// Circular buffer of auxiliary results with per-entry valid and kill-by-address.
// Push/pop take effect at the clock edge; the caller guarantees no push when full.
module rf_arb_buf
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [REG_ADDR_W-1:0]             push_addr,
  input  logic [DATA_W-1:0]                 push_data,
  input  logic                              pop,
  input  logic                              kill,
  input  logic [REG_ADDR_W-1:0]             kill_addr,
  output rf_entry_t                         head,
  output logic [CNT_W-1:0]                  count,
  output logic [DEPTH-1:0]                  valid_vec,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]  addr_vec
);
  localparam int PTR_W = $clog2(DEPTH);

  rf_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && mem[i].valid && (mem[i].addr == kill_addr)) mem[i].valid <= 1'b0;
      end
      if (pop) begin
        mem[head_ptr].valid <= 1'b0;
        head_ptr            <= wrap_inc(head_ptr);
      end
      // Push is last so a same-edge enqueue is never hit by the kill above.
      if (push) begin
        mem[tail_ptr] <= '{valid: 1'b1, addr: push_addr, data: push_data};
        tail_ptr      <= wrap_inc(tail_ptr);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[head_ptr];

  always_comb begin
    valid_vec = '0;
    addr_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = mem[i].valid;
      addr_vec[i]  = mem[i].addr;
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: write-back wins combinationally (0 cycles), buffered aux results fill idle slots.
// Aux side is valid/ready with registered ready; optional starvation stall under RF_ARB_STARVE_EN.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
`ifdef RF_ARB_STARVE_EN
  , parameter int STARVE_MAX = 4
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0]     wb_wdata,
  input  logic                  aux_valid,
  output logic                  aux_ready,
  input  logic [REG_ADDR_W-1:0] aux_waddr,
  input  logic [DATA_W-1:0]     aux_wdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [31:0]           reg_busy,
  output logic                  stall_req
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  rf_entry_t                        head;
  logic [CNT_W-1:0]                 count;
  logic [DEPTH-1:0]                 valid_vec;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_vec;
  logic                             wb_active;
  logic                             head_present;
  logic                             push;
  logic                             pop;

  assign wb_active    = wb_we && (wb_waddr != REG_ZERO);
  assign head_present = (count != '0);
  assign aux_ready    = (count < CNT_W'(DEPTH));
  assign push         = aux_valid && aux_ready && (aux_waddr != REG_ZERO);
  // A killed head leaves without using the write port, so it drains even under write-back.
  assign pop          = head_present && (!head.valid || !wb_active);

  rf_arb_buf #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (aux_waddr),
    .push_data (aux_wdata),
    .pop       (pop),
    .kill      (wb_active),
    .kill_addr (wb_waddr),
    .head      (head),
    .count     (count),
    .valid_vec (valid_vec),
    .addr_vec  (addr_vec)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = REG_ZERO;
    rf_wdata = '0;
    if (!reset) begin
      if (wb_active) begin
        rf_we    = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end else if (head_present && head.valid) begin
        rf_we    = 1'b1;
        rf_waddr = head.addr;
        rf_wdata = head.data;
      end
    end
  end

  always_comb begin
    reg_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_vec[i]) reg_busy[addr_vec[i]] = 1'b1;
    end
  end

`ifdef RF_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_nxt;
  logic          stall_q;

  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || !head_present) starve_nxt = '0;
    else if (head.valid && wb_active && (starve_cnt != SW'(STARVE_MAX))) starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      stall_q    <= (starve_nxt == SW'(STARVE_MAX));
    end
  end

  assign stall_req = stall_q;
`else
  assign stall_req = 1'b0;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed test-plan steps followed by random traffic, all checked against a queue-based reference model.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  localparam int DEPTH = 2;
`ifdef RF_ARB_STARVE_EN
  localparam int SMAX = 4;
  int sc = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_waddr;
  logic [31:0] aux_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] reg_busy;
  logic        stall_req;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .aux_valid (aux_valid),
    .aux_ready (aux_ready),
    .aux_waddr (aux_waddr),
    .aux_wdata (aux_wdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .reg_busy  (reg_busy),
    .stall_req (stall_req)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pending aux results in arrival order.
  rf_entry_t q[$];
  logic      exp_stall = 1'b0;

  logic        obs_we;
  logic [4:0]  obs_waddr;
  logic [31:0] obs_wdata;
  logic [31:0] obs_busy;
  logic        obs_ready;
  logic        obs_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_busy;
    logic        act;
    logic        had;
    logic        hv;
    logic        rdy;
    logic        popped;
    @(negedge clk);
    reset = 1'b0; wb_we = we; wb_waddr = wa; wb_wdata = wd;
    aux_valid = av; aux_waddr = aa; aux_wdata = ad;
    #1;
    act = we && (wa != 5'd0);
    had = (q.size() > 0);
    hv  = had && q[0].valid;
    rdy = (q.size() < DEPTH);
    e_we = 1'b0; e_wa = '0; e_wd = '0; e_busy = '0;
    if (act) begin
      e_we = 1'b1; e_wa = wa; e_wd = wd;
    end else if (hv) begin
      e_we = 1'b1; e_wa = q[0].addr; e_wd = q[0].data;
    end
    foreach (q[i]) if (q[i].valid) e_busy[q[i].addr] = 1'b1;
    obs_we = rf_we; obs_waddr = rf_waddr; obs_wdata = rf_wdata;
    obs_busy = reg_busy; obs_ready = aux_ready; obs_stall = stall_req;
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(e_wa));
    chk("rf_wdata", rf_wdata, e_wd);
    chk("reg_busy", reg_busy, e_busy);
    chk("aux_ready", 32'(aux_ready), 32'(rdy));
    chk("stall_req", 32'(stall_req), 32'(exp_stall));
    @(posedge clk);
    popped = had && (!q[0].valid || !act);
    if (popped) void'(q.pop_front());
    if (act) foreach (q[i]) if (q[i].addr == wa) q[i].valid = 1'b0;
    if (av && rdy && (aa != 5'd0)) q.push_back('{valid: 1'b1, addr: aa, data: ad});
`ifdef RF_ARB_STARVE_EN
    if (popped || !had) sc = 0;
    else if (hv && act && sc < SMAX) sc++;
    exp_stall = (sc == SMAX);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h5555;
    aux_valid = 1'b1; aux_waddr = 5'd9; aux_wdata = 32'h1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_aux_ready", 32'(aux_ready), 32'd1);
    chk("rst_reg_busy", reg_busy, 32'd0);
    chk("rst_stall_req", 32'(stall_req), 32'd0);
    @(posedge clk);
    q.delete();
    exp_stall = 1'b0;
`ifdef RF_ARB_STARVE_EN
    sc = 0;
`endif
  endtask

  initial begin
    reset = 1'b1; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    aux_valid = 1'b0; aux_waddr = '0; aux_wdata = '0;

    // Reset priority: write-back held during reset, then granted at once.
    do_reset();
    cycle(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
    chk("post_rst_we", 32'(obs_we), 32'd1);
    chk("post_rst_waddr", 32'(obs_waddr), 32'd5);

    // Idle aux write.
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h1234);
    chk("idle_aux_ready", 32'(obs_ready), 32'd1);
    chk("idle_aux_no_bypass", 32'(obs_we), 32'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("idle_aux_busy", obs_busy, 32'h100);
    chk("idle_aux_waddr", 32'(obs_waddr), 32'd8);
    chk("idle_aux_wdata", obs_wdata, 32'h1234);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("idle_aux_busy_clr", obs_busy, 32'h0);

    // Full buffer under continuous write-back.
    cycle(1'b1, 5'd9, 32'h9001, 1'b1, 5'd3, 32'h33);
    cycle(1'b1, 5'd9, 32'h9002, 1'b1, 5'd4, 32'h44);
    cycle(1'b1, 5'd9, 32'h9003, 1'b1, 5'd10, 32'hA0);
    chk("full_ready", 32'(obs_ready), 32'd0);
    chk("full_wb_waddr", 32'(obs_waddr), 32'd9);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("drain_first", 32'(obs_waddr), 32'd3);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("drain_second", 32'(obs_waddr), 32'd4);

    // Kill: buffered r7 overwritten by write-back; same-edge enqueue survives.
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAAAA);
    cycle(1'b1, 5'd7, 32'hBBBB, 1'b1, 5'd7, 32'hCCCC);
    chk("kill_wb_data", obs_wdata, 32'hBBBB);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("kill_discard_we", 32'(obs_we), 32'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("kill_survivor", obs_wdata, 32'hCCCC);

    // Register 0 on both producers.
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("r0_busy", obs_busy, 32'h0);
    chk("r0_no_write", 32'(obs_we), 32'd0);
    cycle(1'b1, 5'd0, 32'hBEEF, 1'b1, 5'd12, 32'hC12);
    chk("wb_r0_no_write", 32'(obs_we), 32'd0);
    cycle(1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'h0);
    chk("wb_r0_grant", 32'(obs_waddr), 32'd12);

    // Starvation: one entry held off by four write-back cycles.
    cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd20, 32'h2020);
    for (int k = 0; k < 4; k++) cycle(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0);
`ifdef RF_ARB_STARVE_EN
    chk("starve_not_early", 32'(obs_stall), 32'd0);
`endif
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("starve_entry_written", 32'(obs_waddr), 32'd20);
`ifdef RF_ARB_STARVE_EN
    chk("starve_raised", 32'(obs_stall), 32'd1);
`endif
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("starve_dropped", 32'(obs_stall), 32'd0);

    // Random traffic with occasional mid-transfer resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
